// File: rtl/ibex_wb_pkg.sv
// ibex_wb_pkg: shared types and constants for the register-file writeback arbiter.
//   REG_ADDR_W  : register address width (5)
//   WB_DATA_W   : stored load-data width. DataWidth must not exceed this value.
//   REG_ZERO    : address of the hard-wired zero register
//   wb_entry_t  : one load-queue entry {valid, waddr, data, filled, killed, err}
package ibex_wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WB_DATA_W  = 32;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0]  data;
        logic                  filled;
        logic                  killed;
        logic                  err;
    } wb_entry_t;

    // A write to x0, or to x16..x31 in a 16-register file, must not reach the register file.
    function automatic logic wb_write_suppressed(input logic [REG_ADDR_W-1:0] waddr,
                                                 input logic                  rv32e);
        return (waddr == REG_ZERO) || (rv32e && waddr[REG_ADDR_W-1]);
    endfunction

endpackage

// File: rtl/ibex_wb_load_queue.sv
// ibex_wb_load_queue: in-order queue of outstanding loads with a pending-destination
// scoreboard. Entries are allocated at issue, filled by responses in issue order and
// drained at the head when the parent asserts pop.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   ex_we, ex_waddr     : ALU writeback, kills older entries targeting the same register
//   issue, issue_waddr  : load issue (ignored while the queue is full)
//   rvalid, rdata, rerr : load response for the entry at the fill pointer
//   pop                 : remove the head entry this cycle
//   issue_ready_c       : queue has a free entry (decode of the occupancy register)
//   head_*_c            : fields of the entry at the drain pointer
//   fill_head_c         : the next response would fill the head entry
//   pending_c           : bit r set while a live (unkilled) entry targets register r
//   protocol_err        : sticky, a response arrived with no unfilled entry
module ibex_wb_load_queue
    import ibex_wb_pkg::*;
#(
    parameter int unsigned LoadQDepth = 2,
    parameter int unsigned DataWidth  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_we,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic                  issue,
    input  logic [REG_ADDR_W-1:0] issue_waddr,
    input  logic                  rvalid,
    input  logic [DataWidth-1:0]  rdata,
    input  logic                  rerr,
    input  logic                  pop,
    output logic                  issue_ready_c,
    output logic                  head_valid_c,
    output logic                  head_filled_c,
    output logic                  head_killed_c,
    output logic                  head_err_c,
    output logic [REG_ADDR_W-1:0] head_waddr_c,
    output logic [DataWidth-1:0]  head_data_c,
    output logic                  fill_head_c,
    output logic [NUM_REGS-1:0]   pending_c,
    output logic                  protocol_err
);

    localparam int unsigned PtrW = (LoadQDepth > 1) ? $clog2(LoadQDepth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    wb_entry_t       entries_q [LoadQDepth];
    logic [PtrW-1:0] alloc_ptr_q;
    logic [PtrW-1:0] fill_ptr_q;
    logic [PtrW-1:0] drain_ptr_q;
    logic [CntW-1:0] count_q;

    wb_entry_t head;
    wb_entry_t fill_ent;
    logic      fill_ok;
    logic      do_alloc;
    logic      do_fill;

    // Entries between fill and alloc are the unfilled ones, so checking the slot at the
    // fill pointer is enough to know whether any unfilled entry exists.
    assign head     = entries_q[drain_ptr_q];
    assign fill_ent = entries_q[fill_ptr_q];
    assign fill_ok  = fill_ent.valid && !fill_ent.filled;
    assign do_alloc = issue && issue_ready_c;
    assign do_fill  = rvalid && fill_ok;

    assign issue_ready_c = (count_q != CntW'(LoadQDepth));
    assign fill_head_c   = fill_ok && (fill_ptr_q == drain_ptr_q);

    assign head_valid_c  = head.valid;
    assign head_filled_c = head.filled;
    assign head_killed_c = head.killed;
    assign head_err_c    = head.err;
    assign head_waddr_c  = head.waddr;
    assign head_data_c   = DataWidth'(head.data);

    // Entry storage and pointers. A pop issued together with a fill of the same slot
    // (load bypass) leaves the slot empty because the pop clear is applied last.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(LoadQDepth); i++) begin
                entries_q[i] <= '0;
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            drain_ptr_q <= '0;
            count_q     <= '0;
        end else begin
            for (int i = 0; i < int'(LoadQDepth); i++) begin
                if (ex_we && entries_q[i].valid && (entries_q[i].waddr == ex_waddr)) begin
                    entries_q[i].killed <= 1'b1;
                end
            end
            if (do_fill) begin
                entries_q[fill_ptr_q].filled <= 1'b1;
                entries_q[fill_ptr_q].data   <= WB_DATA_W'(rdata);
                entries_q[fill_ptr_q].err    <= rerr;
                fill_ptr_q                   <= fill_ptr_q + PtrW'(1);
            end
            if (pop) begin
                entries_q[drain_ptr_q] <= '0;
                drain_ptr_q            <= drain_ptr_q + PtrW'(1);
            end
            if (do_alloc) begin
                entries_q[alloc_ptr_q].valid  <= 1'b1;
                entries_q[alloc_ptr_q].waddr  <= issue_waddr;
                entries_q[alloc_ptr_q].data   <= '0;
                entries_q[alloc_ptr_q].filled <= 1'b0;
                entries_q[alloc_ptr_q].killed <= 1'b0;
                entries_q[alloc_ptr_q].err    <= 1'b0;
                alloc_ptr_q                   <= alloc_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(do_alloc) - CntW'(pop);
        end
    end

    // Sticky protocol error for responses that match no outstanding load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            protocol_err <= 1'b0;
        end else if (rvalid && !fill_ok) begin
            protocol_err <= 1'b1;
        end
    end

    // Scoreboard decode; x0 never reports pending.
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < int'(LoadQDepth); i++) begin
            if (entries_q[i].valid && !entries_q[i].killed) begin
                pending_c[entries_q[i].waddr] = 1'b1;
            end
        end
        pending_c[REG_ZERO] = 1'b0;
    end

endmodule

// File: rtl/ibex_wb_arbiter.sv
// ibex_wb_arbiter: merges ALU writebacks and in-order load responses into the single
// register-file write port and exports the pending-load scoreboard.
// Optional feature: define IBEX_WB_LOAD_BYPASS_EN to write a head-entry load response
// straight to the write port one cycle earlier when the port is otherwise idle.
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   ex_we_i/ex_waddr_i/ex_wdata_i : ALU writeback (highest priority)
//   lsu_issue_i/lsu_issue_waddr_i : load issue, allocates a queue entry
//   lsu_issue_ready_o             : queue has a free entry
//   lsu_rvalid_i/rdata_i/err_i    : load response, in issue order
//   waddr_a_o/wdata_a_o/we_a_o    : registered register-file write port
//   pending_o                     : registers with a live outstanding load
//   protocol_err_o                : sticky, response with no outstanding load
module ibex_wb_arbiter
    import ibex_wb_pkg::*;
#(
    parameter bit          RV32E      = 1'b0,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned LoadQDepth = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_we_i,
    input  logic [REG_ADDR_W-1:0] ex_waddr_i,
    input  logic [DataWidth-1:0]  ex_wdata_i,
    input  logic                  lsu_issue_i,
    input  logic [REG_ADDR_W-1:0] lsu_issue_waddr_i,
    output logic                  lsu_issue_ready_o,
    input  logic                  lsu_rvalid_i,
    input  logic [DataWidth-1:0]  lsu_rdata_i,
    input  logic                  lsu_err_i,
    output logic [REG_ADDR_W-1:0] waddr_a_o,
    output logic [DataWidth-1:0]  wdata_a_o,
    output logic                  we_a_o,
    output logic [NUM_REGS-1:0]   pending_o,
    output logic                  protocol_err_o
);

    logic                  pop;
    logic                  head_valid;
    logic                  head_filled;
    logic                  head_killed;
    logic                  head_err;
    logic [REG_ADDR_W-1:0] head_waddr;
    logic [DataWidth-1:0]  head_data;
    logic                  fill_head;

    logic                  we_q,    we_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;

    ibex_wb_load_queue #(
        .LoadQDepth (LoadQDepth),
        .DataWidth  (DataWidth)
    ) u_load_queue (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ex_we         (ex_we_i),
        .ex_waddr      (ex_waddr_i),
        .issue         (lsu_issue_i),
        .issue_waddr   (lsu_issue_waddr_i),
        .rvalid        (lsu_rvalid_i),
        .rdata         (lsu_rdata_i),
        .rerr          (lsu_err_i),
        .pop           (pop),
        .issue_ready_c (lsu_issue_ready_o),
        .head_valid_c  (head_valid),
        .head_filled_c (head_filled),
        .head_killed_c (head_killed),
        .head_err_c    (head_err),
        .head_waddr_c  (head_waddr),
        .head_data_c   (head_data),
        .fill_head_c   (fill_head),
        .pending_c     (pending_o),
        .protocol_err  (protocol_err_o)
    );

    // Write-port selection: ALU first, then a filled head entry. Killed or errored
    // entries are retired without a write and leave address/data untouched.
    always_comb begin
        pop     = 1'b0;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (ex_we_i) begin
            we_d    = !wb_write_suppressed(ex_waddr_i, RV32E);
            waddr_d = ex_waddr_i;
            wdata_d = ex_wdata_i;
        end else if (head_valid && head_filled) begin
            pop = 1'b1;
            if (!head_killed && !head_err) begin
                we_d    = !wb_write_suppressed(head_waddr, RV32E);
                waddr_d = head_waddr;
                wdata_d = head_data;
            end
        end
`ifdef IBEX_WB_LOAD_BYPASS_EN
        // Head response on an idle port goes straight to the write registers.
        else if (lsu_rvalid_i && !lsu_err_i && fill_head && !head_killed) begin
            pop     = 1'b1;
            we_d    = !wb_write_suppressed(head_waddr, RV32E);
            waddr_d = head_waddr;
            wdata_d = lsu_rdata_i;
        end
`endif
    end

`ifndef IBEX_WB_LOAD_BYPASS_EN
    logic unused_fill_head;
    assign unused_fill_head = fill_head;
`endif

    // Registered write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_a_o    = we_q;
    assign waddr_a_o = waddr_q;
    assign wdata_a_o = wdata_q;

endmodule
